// File: rtl/cpl_enqueue_arbiter_if.sv
// Bundle of requester-side and manager-side enqueue/response/commit signals for cpl_enqueue_arbiter.
// slave = arbiter view; master = the requesters plus the queue manager around it.
interface cpl_enqueue_arbiter_if #(
  parameter int PORTS             = 4,
  parameter int QUEUE_INDEX_WIDTH = 8,
  parameter int S_REQ_TAG_WIDTH   = 8,
  parameter int M_REQ_TAG_WIDTH   = S_REQ_TAG_WIDTH + $clog2(PORTS),
  parameter int OP_TAG_WIDTH      = 8,
  parameter int QUEUE_PTR_WIDTH   = 16
);
  logic [PORTS*QUEUE_INDEX_WIDTH-1:0] s_enq_req_queue;
  logic [PORTS*S_REQ_TAG_WIDTH-1:0]   s_enq_req_tag;
  logic [PORTS-1:0]                   s_enq_req_valid;
  logic [PORTS-1:0]                   s_enq_req_ready;

  logic [QUEUE_INDEX_WIDTH-1:0]       m_enq_req_queue;
  logic [M_REQ_TAG_WIDTH-1:0]         m_enq_req_tag;
  logic                               m_enq_req_valid;
  logic                               m_enq_req_ready;

  logic [QUEUE_PTR_WIDTH-1:0]         m_enq_resp_ptr;
  logic [OP_TAG_WIDTH-1:0]            m_enq_resp_op_tag;
  logic [M_REQ_TAG_WIDTH-1:0]         m_enq_resp_tag;
  logic                               m_enq_resp_full;
  logic                               m_enq_resp_error;
  logic                               m_enq_resp_valid;
  logic                               m_enq_resp_ready;

  logic [QUEUE_PTR_WIDTH-1:0]         s_enq_resp_ptr;
  logic [OP_TAG_WIDTH-1:0]            s_enq_resp_op_tag;
  logic [S_REQ_TAG_WIDTH-1:0]         s_enq_resp_tag;
  logic                               s_enq_resp_full;
  logic                               s_enq_resp_error;
  logic [PORTS-1:0]                   s_enq_resp_valid;
  logic [PORTS-1:0]                   s_enq_resp_ready;

  logic [PORTS*OP_TAG_WIDTH-1:0]      s_commit_op_tag;
  logic [PORTS-1:0]                   s_commit_valid;
  logic [PORTS-1:0]                   s_commit_ready;

  logic [OP_TAG_WIDTH-1:0]            m_commit_op_tag;
  logic                               m_commit_valid;
  logic                               m_commit_ready;

  modport slave (
    input  s_enq_req_queue, s_enq_req_tag, s_enq_req_valid,
    output s_enq_req_ready,
    output m_enq_req_queue, m_enq_req_tag, m_enq_req_valid,
    input  m_enq_req_ready,
    input  m_enq_resp_ptr, m_enq_resp_op_tag, m_enq_resp_tag, m_enq_resp_full,
    input  m_enq_resp_error, m_enq_resp_valid,
    output m_enq_resp_ready,
    output s_enq_resp_ptr, s_enq_resp_op_tag, s_enq_resp_tag, s_enq_resp_full,
    output s_enq_resp_error, s_enq_resp_valid,
    input  s_enq_resp_ready,
    input  s_commit_op_tag, s_commit_valid,
    output s_commit_ready,
    output m_commit_op_tag, m_commit_valid,
    input  m_commit_ready
  );

  modport master (
    output s_enq_req_queue, s_enq_req_tag, s_enq_req_valid,
    input  s_enq_req_ready,
    input  m_enq_req_queue, m_enq_req_tag, m_enq_req_valid,
    output m_enq_req_ready,
    output m_enq_resp_ptr, m_enq_resp_op_tag, m_enq_resp_tag, m_enq_resp_full,
    output m_enq_resp_error, m_enq_resp_valid,
    input  m_enq_resp_ready,
    input  s_enq_resp_ptr, s_enq_resp_op_tag, s_enq_resp_tag, s_enq_resp_full,
    input  s_enq_resp_error, s_enq_resp_valid,
    output s_enq_resp_ready,
    output s_commit_op_tag, s_commit_valid,
    input  s_commit_ready,
    input  m_commit_op_tag, m_commit_valid,
    output m_commit_ready
  );
endinterface

// File: rtl/cpl_enqueue_arbiter.sv
// Round-robin share of the CQ manager enqueue/commit ports; 1-cycle request/commit registers, 0-cycle response demux.
// Grants only when the output register is empty or draining; CPL_ARB_OUTSTANDING_LIMIT_EN adds per-port in-flight caps.
module cpl_enqueue_arbiter #(
  parameter int PORTS             = 4,
  parameter int QUEUE_INDEX_WIDTH = 8,
  parameter int S_REQ_TAG_WIDTH   = 8,
  parameter int M_REQ_TAG_WIDTH   = S_REQ_TAG_WIDTH + $clog2(PORTS),
  parameter int OP_TAG_WIDTH      = 8,
  parameter int QUEUE_PTR_WIDTH   = 16,
  parameter int MAX_OUTSTANDING   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  cpl_enqueue_arbiter_if.slave bus
);
  localparam int PIW = $clog2(PORTS);
  localparam int QW  = QUEUE_INDEX_WIDTH;
  localparam int STW = S_REQ_TAG_WIDTH;
  localparam int OTW = OP_TAG_WIDTH;

  // Returns {found, index} of the first set bit at or after ptr, wrapping modulo PORTS.
  function automatic logic [PIW:0] rr_pick(input logic [PORTS-1:0] elig, input logic [PIW-1:0] ptr);
    logic [PIW:0] res;
    logic [PIW:0] idx;
    res = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (PIW+1)'(k);
      if (idx >= (PIW+1)'(PORTS)) idx = idx - (PIW+1)'(PORTS);
      if (elig[idx[PIW-1:0]]) res = {1'b1, idx[PIW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [PIW-1:0] rr_next(input logic [PIW-1:0] g);
    return (g == PIW'(PORTS - 1)) ? '0 : g + 1'b1;
  endfunction

  logic [PORTS-1:0]           req_elig;
  logic [PIW:0]               req_pick;
  logic                       req_load, req_fire;
  logic [PIW-1:0]             req_grant, req_ptr;
  logic [PORTS-1:0]           req_rdy;
  logic                       req_vld;
  logic [QW-1:0]              req_queue;
  logic [M_REQ_TAG_WIDTH-1:0] req_tag;

  logic [PIW:0]               cmt_pick;
  logic                       cmt_load, cmt_fire;
  logic [PIW-1:0]             cmt_grant, cmt_ptr;
  logic [PORTS-1:0]           cmt_rdy;
  logic                       cmt_vld;
  logic [OTW-1:0]             cmt_tag;

  // Request arbitration and output register
  assign req_load  = rst_n && (!req_vld || bus.m_enq_req_ready);
  assign req_pick  = rr_pick(req_elig, req_ptr);
  assign req_fire  = req_load && req_pick[PIW];
  assign req_grant = req_pick[PIW-1:0];
  assign req_rdy   = PORTS'(req_fire) << req_grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_vld   <= 1'b0;
      req_ptr   <= '0;
      req_queue <= '0;
      req_tag   <= '0;
    end else if (req_load) begin
      req_vld <= req_fire;
      if (req_fire) begin
        req_queue <= bus.s_enq_req_queue[req_grant*QW +: QW];
        req_tag   <= {req_grant, bus.s_enq_req_tag[req_grant*STW +: STW]};
        req_ptr   <= rr_next(req_grant);
      end
    end
  end

  assign bus.s_enq_req_ready = req_rdy;
  assign bus.m_enq_req_valid = req_vld;
  assign bus.m_enq_req_queue = req_queue;
  assign bus.m_enq_req_tag   = req_tag;

  // Commit arbitration: same rule, independent pointer
  assign cmt_load  = rst_n && (!cmt_vld || bus.m_commit_ready);
  assign cmt_pick  = rr_pick(bus.s_commit_valid, cmt_ptr);
  assign cmt_fire  = cmt_load && cmt_pick[PIW];
  assign cmt_grant = cmt_pick[PIW-1:0];
  assign cmt_rdy   = PORTS'(cmt_fire) << cmt_grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmt_vld <= 1'b0;
      cmt_ptr <= '0;
      cmt_tag <= '0;
    end else if (cmt_load) begin
      cmt_vld <= cmt_fire;
      if (cmt_fire) begin
        cmt_tag <= bus.s_commit_op_tag[cmt_grant*OTW +: OTW];
        cmt_ptr <= rr_next(cmt_grant);
      end
    end
  end

  assign bus.s_commit_ready  = cmt_rdy;
  assign bus.m_commit_valid  = cmt_vld;
  assign bus.m_commit_op_tag = cmt_tag;

`ifdef CPL_ARB_OUTSTANDING_LIMIT_EN
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [CW-1:0] count [PORTS];

  always_comb begin
    req_elig = '0;
    for (int i = 0; i < PORTS; i++)
      req_elig[i] = bus.s_enq_req_valid[i] && (count[i] < CW'(MAX_OUTSTANDING));
  end

  // A commit on an idle port is accepted but never underflows the counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PORTS; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (req_rdy[i] && !cmt_rdy[i])
          count[i] <= count[i] + 1'b1;
        else if (cmt_rdy[i] && !req_rdy[i] && count[i] != '0)
          count[i] <= count[i] - 1'b1;
      end
    end
  end
`else
  assign req_elig = bus.s_enq_req_valid;
  if (MAX_OUTSTANDING < 1) begin : g_bad_max_outstanding
  end
`endif

  // Response demux by the port index carried in the tag's upper bits
  logic [PIW-1:0] resp_port;
  logic           resp_in_range;
  logic [PORTS-1:0] resp_vld;

  assign resp_port     = bus.m_enq_resp_tag[M_REQ_TAG_WIDTH-1 -: PIW];
  assign resp_in_range = ({1'b0, resp_port} < (PIW+1)'(PORTS));

  always_comb begin
    resp_vld = '0;
    if (bus.m_enq_resp_valid && resp_in_range) resp_vld[resp_port] = 1'b1;
  end

  assign bus.s_enq_resp_valid  = resp_vld;
  assign bus.m_enq_resp_ready  = resp_in_range ? bus.s_enq_resp_ready[resp_port] : 1'b1;
  assign bus.s_enq_resp_ptr    = bus.m_enq_resp_ptr;
  assign bus.s_enq_resp_op_tag = bus.m_enq_resp_op_tag;
  assign bus.s_enq_resp_tag    = bus.m_enq_resp_tag[STW-1:0];
  assign bus.s_enq_resp_full   = bus.m_enq_resp_full;
  assign bus.s_enq_resp_error  = bus.m_enq_resp_error;
endmodule

// File: tb/tb_cpl_enqueue_arbiter.sv
// Bench for cpl_enqueue_arbiter: directed scenarios plus random traffic against a queue/array model.
module tb_cpl_enqueue_arbiter;
  localparam int P = 4, QW = 8, STW = 8, MTW = 10, OTW = 8, PW = 16;
`ifdef CPL_ARB_OUTSTANDING_LIMIT_EN
  localparam int MAXO = 2;
`else
  localparam int MAXO = 16;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpl_enqueue_arbiter_if #(.PORTS(P), .QUEUE_INDEX_WIDTH(QW), .S_REQ_TAG_WIDTH(STW),
    .M_REQ_TAG_WIDTH(MTW), .OP_TAG_WIDTH(OTW), .QUEUE_PTR_WIDTH(PW)) bus ();

  cpl_enqueue_arbiter #(.PORTS(P), .QUEUE_INDEX_WIDTH(QW), .S_REQ_TAG_WIDTH(STW),
    .M_REQ_TAG_WIDTH(MTW), .OP_TAG_WIDTH(OTW), .QUEUE_PTR_WIDTH(PW),
    .MAX_OUTSTANDING(MAXO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  // requester / manager stimulus
  bit             req_v [P];
  logic [QW-1:0]  req_q [P];
  logic [STW-1:0] req_t [P];
  bit             cmt_v [P];
  logic [OTW-1:0] cmt_t [P];
  logic [P-1:0]   resp_rdy;
  bit             m_req_rdy, m_cmt_rdy, resp_v, resp_full, resp_err;
  logic [MTW-1:0] resp_tag;
  logic [OTW-1:0] resp_op;
  logic [PW-1:0]  resp_ptr;

  // model state
  bit             o_vld, co_vld;
  int             o_port, mdl_req_ptr, mdl_cmt_ptr;
  logic [QW-1:0]  o_q;
  logic [STW-1:0] o_t;
  logic [OTW-1:0] co_t;
  int             cnt [P];
  logic [P-1:0]   obs_req_rdy, obs_cmt_rdy;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit e [P], input int ptr);
    for (int k = 0; k < P; k++)
      if (e[(ptr + k) % P]) return (ptr + k) % P;
    return -1;
  endfunction

  function automatic bit under_limit(input int i);
`ifdef CPL_ARB_OUTSTANDING_LIMIT_EN
    return cnt[i] < MAXO;
`else
    return 1'b1;
`endif
  endfunction

  task automatic apply();
    for (int i = 0; i < P; i++) begin
      bus.s_enq_req_valid[i]            = req_v[i];
      bus.s_enq_req_queue[i*QW +: QW]   = req_q[i];
      bus.s_enq_req_tag[i*STW +: STW]   = req_t[i];
      bus.s_commit_valid[i]             = cmt_v[i];
      bus.s_commit_op_tag[i*OTW +: OTW] = cmt_t[i];
    end
    bus.m_enq_req_ready   = m_req_rdy;
    bus.m_commit_ready    = m_cmt_rdy;
    bus.m_enq_resp_valid  = resp_v;
    bus.m_enq_resp_tag    = resp_tag;
    bus.m_enq_resp_op_tag = resp_op;
    bus.m_enq_resp_ptr    = resp_ptr;
    bus.m_enq_resp_full   = resp_full;
    bus.m_enq_resp_error  = resp_err;
    bus.s_enq_resp_ready  = resp_rdy;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit e [P];
    bit ce [P];
    bit load, cload;
    int g, cg, rp;
    logic [P-1:0] er, ecr, erv;
    apply();
    @(negedge clk);
    load  = !o_vld || m_req_rdy;
    cload = !co_vld || m_cmt_rdy;
    for (int i = 0; i < P; i++) begin
      e[i]  = req_v[i] && under_limit(i);
      ce[i] = cmt_v[i];
    end
    g  = (rst_n && load)  ? pick(e, mdl_req_ptr)  : -1;
    cg = (rst_n && cload) ? pick(ce, mdl_cmt_ptr) : -1;
    er = '0;  if (g >= 0)  er[g]  = 1'b1;
    ecr = '0; if (cg >= 0) ecr[cg] = 1'b1;
    obs_req_rdy = bus.s_enq_req_ready;
    obs_cmt_rdy = bus.s_commit_ready;
    chk("req_ready", obs_req_rdy, er);
    chk("cmt_ready", obs_cmt_rdy, ecr);
    chk("req_valid", bus.m_enq_req_valid, o_vld);
    if (o_vld)
      chk("req_data", {bus.m_enq_req_queue, bus.m_enq_req_tag}, {o_q, 2'(o_port), o_t});
    chk("cmt_valid", bus.m_commit_valid, co_vld);
    if (co_vld) chk("cmt_tag", bus.m_commit_op_tag, co_t);
    rp = int'(resp_tag) / (1 << STW);
    erv = '0; if (resp_v) erv[rp] = 1'b1;
    chk("resp_valid", bus.s_enq_resp_valid, erv);
    chk("resp_ready", bus.m_enq_resp_ready, resp_rdy[rp]);
    chk("resp_data", {bus.s_enq_resp_ptr, bus.s_enq_resp_op_tag, bus.s_enq_resp_tag,
                      bus.s_enq_resp_full, bus.s_enq_resp_error},
        {resp_ptr, resp_op, resp_tag[STW-1:0], resp_full, resp_err});
    @(posedge clk);
    if (!rst_n) begin
      o_vld = 0; co_vld = 0; mdl_req_ptr = 0; mdl_cmt_ptr = 0;
      for (int i = 0; i < P; i++) cnt[i] = 0;
    end else begin
      if (load) begin
        o_vld = (g >= 0);
        if (g >= 0) begin
          o_port = g; o_q = req_q[g]; o_t = req_t[g];
          mdl_req_ptr = (g + 1) % P; req_v[g] = 0;
        end
      end
      if (cload) begin
        co_vld = (cg >= 0);
        if (cg >= 0) begin
          co_t = cmt_t[cg]; mdl_cmt_ptr = (cg + 1) % P; cmt_v[cg] = 0;
        end
      end
      if (g >= 0 && g != cg) cnt[g]++;
      if (cg >= 0 && cg != g && cnt[cg] > 0) cnt[cg]--;
    end
    #1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < P; i++) begin
      req_v[i] = 0; cmt_v[i] = 0;
    end
    resp_v = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  logic [MTW-1:0] rr_tags [5] = '{10'h010, 10'h111, 10'h212, 10'h313, 10'h010};

  initial begin
    for (int i = 0; i < P; i++) begin
      req_v[i] = 0; req_q[i] = '0; req_t[i] = '0; cmt_v[i] = 0; cmt_t[i] = '0; cnt[i] = 0;
    end
    m_req_rdy = 1; m_cmt_rdy = 1; resp_v = 0; resp_tag = '0; resp_op = '0; resp_ptr = '0;
    resp_full = 0; resp_err = 0; resp_rdy = '1;
    o_vld = 0; co_vld = 0; o_port = 0; o_q = '0; o_t = '0; co_t = '0;
    mdl_req_ptr = 0; mdl_cmt_ptr = 0;

    step();
    do_reset();
    chk("rst_req_valid", bus.m_enq_req_valid, 1'b0);
    chk("rst_cmt_valid", bus.m_commit_valid, 1'b0);

    // all ports valid: round-robin one grant per cycle
    for (int i = 0; i < P; i++) begin
      req_v[i] = 1; req_q[i] = QW'(8'h20 + i); req_t[i] = STW'(8'h10 + i);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_tag", bus.m_enq_req_tag, rr_tags[k]);
      for (int i = 0; i < P; i++) req_v[i] = 1;
    end
    clear_all();
    step(); step();

    // response routed to port 2 only
    resp_v = 1; resp_tag = 10'h25A; resp_op = 8'd7; resp_ptr = 16'h1234; resp_rdy = 4'b0100;
    step();
    chk("resp_port2_valid", bus.s_enq_resp_valid, 4'b0100);
    chk("resp_port2_tag", bus.s_enq_resp_tag, 8'h5A);
    chk("resp_port2_op", bus.s_enq_resp_op_tag, 8'd7);
    resp_rdy = 4'b1011;
    step();
    chk("resp_stall", bus.m_enq_resp_ready, 1'b0);
    resp_v = 0; resp_rdy = '1;

    // manager stall with ports 1 and 3 waiting
    clear_all(); do_reset();
    req_v[0] = 1; req_q[0] = 8'h00; req_t[0] = 8'h00; m_req_rdy = 1;
    step();
    m_req_rdy = 0;
    req_v[1] = 1; req_q[1] = 8'h31; req_t[1] = 8'hA1;
    req_v[3] = 1; req_q[3] = 8'h33; req_t[3] = 8'hA3;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_no_ready", obs_req_rdy, 4'b0000);
      chk("stall_hold_tag", bus.m_enq_req_tag, 10'h000);
    end
    m_req_rdy = 1;
    step();
    chk("release_first", bus.m_enq_req_tag, 10'h1A1);
    step();
    chk("release_second", bus.m_enq_req_tag, 10'h3A3);

    // reset while a request is registered
    req_v[2] = 1; req_q[2] = 8'h32; req_t[2] = 8'h22;
    step();
    m_req_rdy = 0;
    chk("pre_reset_valid", bus.m_enq_req_valid, 1'b1);
    do_reset();
    chk("mid_reset_valid", bus.m_enq_req_valid, 1'b0);
    req_v[1] = 1; req_v[3] = 1;
    step();
    chk("restart_port0", obs_req_rdy, 4'b0010);
    m_req_rdy = 1;

`ifdef CPL_ARB_OUTSTANDING_LIMIT_EN
    // port 0 capped at two outstanding
    clear_all(); do_reset();
    for (int k = 0; k < 3; k++) begin
      req_v[0] = 1; req_t[0] = STW'(k);
      step();
      chk("limit_grant", obs_req_rdy, (k < 2) ? 4'b0001 : 4'b0000);
    end
    cmt_v[0] = 1; cmt_t[0] = 8'h40;
    step();
    chk("limit_commit", obs_cmt_rdy, 4'b0001);
    chk("limit_still_blocked", obs_req_rdy, 4'b0000);
    step();
    chk("limit_unblocked", obs_req_rdy, 4'b0001);

    // same-cycle request and commit on port 1 at count 1
    clear_all(); do_reset();
    req_v[1] = 1; step();
    req_v[1] = 1; cmt_v[1] = 1; step();
    chk("same_cycle_req", obs_req_rdy, 4'b0010);
    chk("same_cycle_cmt", obs_cmt_rdy, 4'b0010);
    req_v[1] = 1; step();
    chk("count_held_grant", obs_req_rdy, 4'b0010);
    step();
    chk("count_full_block", obs_req_rdy, 4'b0000);
`endif

    // random traffic
    clear_all(); do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < P; i++) begin
        if (!req_v[i] && $urandom_range(2, 0) == 0) begin
          req_v[i] = 1; req_q[i] = QW'($urandom); req_t[i] = STW'($urandom);
        end
        if (!cmt_v[i] && $urandom_range(3, 0) == 0) begin
          cmt_v[i] = 1; cmt_t[i] = OTW'($urandom);
        end
      end
      m_req_rdy = ($urandom_range(3, 0) != 0);
      m_cmt_rdy = ($urandom_range(3, 0) != 0);
      resp_v = $urandom_range(1, 0) == 1;
      resp_tag = MTW'($urandom); resp_op = OTW'($urandom); resp_ptr = PW'($urandom);
      resp_full = $urandom_range(1, 0) == 1; resp_err = $urandom_range(1, 0) == 1;
      resp_rdy = P'($urandom);
      rst_n = ($urandom_range(199, 0) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpl_enqueue_arbiter.md
# cpl_enqueue_arbiter

Shares the single enqueue/commit interface of the completion queue manager between `PORTS` requesters (TX/RX completion writers, event generators). Arbitrates enqueue requests and commits round-robin, extends each request tag with the requester index, and demultiplexes responses back to the originating port by that index. An optional per-port in-flight limit keeps one requester from exhausting the manager's operation table.

## Interface
Parameters:
- `PORTS`, 4, number of requesters (2–16)
- `QUEUE_INDEX_WIDTH`, 8, queue index width
- `S_REQ_TAG_WIDTH`, 8, requester-side tag width
- `M_REQ_TAG_WIDTH`, `S_REQ_TAG_WIDTH+$clog2(PORTS)`, manager-side tag width; upper `$clog2(PORTS)` bits = port index
- `OP_TAG_WIDTH`, 8, manager operation tag width
- `QUEUE_PTR_WIDTH`, 16, queue pointer width
- `MAX_OUTSTANDING`, 16, per-port in-flight limit (limit feature only)

Ports (per-port vectors are flat, port i in slice i):
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `s_enq_req_queue/tag/valid/ready`  in/in/in/out  `PORTS*QUEUE_INDEX_WIDTH`/`PORTS*S_REQ_TAG_WIDTH`/`PORTS`/`PORTS`  requester enqueue requests
- `m_enq_req_queue/tag/valid/ready`  out/out/out/in  `QUEUE_INDEX_WIDTH`/`M_REQ_TAG_WIDTH`/1/1  to manager
- `m_enq_resp_ptr/op_tag/tag/full/error/valid/ready`  in×6/out  `QUEUE_PTR_WIDTH`/`OP_TAG_WIDTH`/`M_REQ_TAG_WIDTH`/1/1/1/1  manager response
- `s_enq_resp_ptr/op_tag/tag/full/error`  out  broadcast fields; `tag` is the stripped `S_REQ_TAG_WIDTH` value
- `s_enq_resp_valid/ready`  out/in  `PORTS`/`PORTS`  per-port response handshake
- `s_commit_op_tag/valid/ready`  in/in/out  `PORTS*OP_TAG_WIDTH`/`PORTS`/`PORTS`  requester commits
- `m_commit_op_tag/valid/ready`  out/out/in  `OP_TAG_WIDTH`/1/1  commit to manager

## Operation
- Request path: one output register. Arbitration runs when the register is empty or being drained (`m_enq_req_valid && m_enq_req_ready`). Grant = first eligible valid port at or after `req_ptr`; load queue, `{port, tag}`, set valid; assert that port's `s_enq_req_ready` in the same cycle; `req_ptr <= grant+1` (mod `PORTS`).
- Eligible: `s_enq_req_valid[i]` and, with limit enabled, `count[i] < MAX_OUTSTANDING`.
- Response path: combinational. Port = `m_enq_resp_tag[M-1 -: clog2(PORTS)]`; only that port sees `s_enq_resp_valid`; `m_enq_resp_ready = s_enq_resp_ready[port]`. An index ≥ `PORTS` is dropped (ready=1, no valid asserted).
- Commit path: independent output register and pointer `cmt_ptr`, same round-robin rule.
- Counters (limit enabled): +1 on request grant, −1 on commit grant for the same port; simultaneous events leave count unchanged. Counter never wraps; commit with count 0 is accepted and count stays 0.
- Requester must hold `valid` and fields until ready; the block never drops a granted request.

## Timing
- Reset (`rst_n=0` at a clock edge): `m_enq_req_valid=0`, `m_commit_valid=0`, `req_ptr=cmt_ptr=0`, counters 0, all `s_*_ready=0`. Reset mid-transfer discards registered request/commit.
- Request latency: accepted at edge N, `m_enq_req_valid` high after edge N; back-to-back grants every cycle while `m_enq_req_ready=1`.
- Response latency 0 cycles; commit latency 1 cycle.
- Stalled manager (`ready=0`): register held, no grants, all `s_enq_req_ready=0`.
- Fairness: any continuously valid eligible port granted within `PORTS` grants.

## Configuration
- `CPL_ARB_OUTSTANDING_LIMIT_EN` defined: per-port `$clog2(MAX_OUTSTANDING+1)`-bit counters built; port at limit is skipped until a commit from it is granted.
- Not defined: no counters; every valid port eligible; `MAX_OUTSTANDING` unused.

## Test plan
- All 4 ports valid continuously, manager ready=1 -> grants 0,1,2,3,0,… one per cycle; `m_enq_req_tag` = `{2'd0,tag0}`, `{2'd1,tag1}`, …
- Port 2 request tag 0x5A, manager replies tag 0x25A, op_tag 7 -> only `s_enq_resp_valid[2]`, `s_enq_resp_tag=0x5A`, op_tag 7; stall with `s_enq_resp_ready[2]=0` holds `m_enq_resp_ready=0`.
- Manager ready=0 for 5 cycles with ports 1,3 valid -> output stable, no `s_enq_req_ready`; release -> port 1 then port 3.
- Limit enabled, MAX_OUTSTANDING=2: port 0 issues 3 requests, no commits -> third blocked; one commit from port 0 -> third granted next arbitration.
- Same-cycle request grant and commit grant on port 1 at count 1 -> count stays 1.
- `rst_n` low for one edge while request registered -> `m_enq_req_valid=0`, arbitration restarts at port 0.
